// File: rtl/mult_seq_16b.sv
// Iterative shift-add multiplier producing a 2N-bit product, one multiplier bit
// per cycle, with a start/busy/done handshake. Includes the cla_16b adder it drives.

module cla_16b #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic [W-1:0] sum,
  output logic         c_out
);

  logic [W-1:0] gen;
  logic [W-1:0] prop;
  logic [W:0]   carry;

  assign gen  = a & b;
  assign prop = a ^ b;

  always_comb begin
    carry[0] = c_in;
    for (int i = 0; i < W; i++) begin
      carry[i+1] = gen[i] | (prop[i] & carry[i]);
    end
  end

  assign sum   = prop ^ carry[W-1:0];
  assign c_out = carry[W];

endmodule

module mult_seq_16b #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           is_signed,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  typedef enum logic [1:0] {IDLE, CALC, NEG, DONE} state_t;

  localparam int             CW      = $clog2(N + 1);
  localparam logic [CW-1:0]  CNT_END = CW'(N);

  state_t         state;
  state_t         next_state;
  logic [N-1:0]   mcand;
  logic [N-1:0]   mplier;
  logic [N-1:0]   acc_hi;
  logic           neg;
  logic [CW-1:0]  cnt;

  logic [N-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic           iterate;
  logic [N-1:0]   lo_a, lo_b, lo_sum;
  logic           lo_cin, lo_cout;
  logic [N-1:0]   hi_a, hi_b, hi_sum;
  logic           hi_cout;
  logic [2*N-1:0] final_result;

  // 0x8000 maps onto itself, which is the correct unsigned magnitude.
  assign a_mag = (is_signed && a[N-1]) ? (~a + N'(1)) : a;
  assign b_mag = (is_signed && b[N-1]) ? (~b + N'(1)) : b;

  // The last CALC cycle (cnt == N) only drains; all N iterations are already registered.
  assign iterate = (state == CALC) && (cnt != CNT_END);

  // Low adder serves the shift-add step in CALC and the low half of the negation in NEG.
  always_comb begin
    lo_a   = acc_hi;
    lo_b   = mplier[0] ? mcand : '0;
    lo_cin = 1'b0;
    hi_a   = ~acc_hi;
    hi_b   = '0;
    if (state == NEG) begin
      lo_a   = ~mplier;
      lo_b   = '0;
      lo_cin = 1'b1;
    end
  end

  cla_16b #(.W(N)) u_add_lo (
    .a     (lo_a),
    .b     (lo_b),
    .c_in  (lo_cin),
    .sum   (lo_sum),
    .c_out (lo_cout)
  );

  cla_16b #(.W(N)) u_add_hi (
    .a     (hi_a),
    .b     (hi_b),
    .c_in  (lo_cout),
    .sum   (hi_sum),
    .c_out (hi_cout)
  );

  assign final_result = (state == NEG) ? {hi_sum, lo_sum} : {acc_hi, mplier};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = CALC;
      CALC:    if (cnt == CNT_END) next_state = neg ? NEG : DONE;
      NEG:     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Working registers; the low product half shifts into mplier as its bits retire.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand   <= '0;
      mplier  <= '0;
      acc_hi  <= '0;
      neg     <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else begin
      if (state == IDLE && start) begin
        mcand  <= a_mag;
        mplier <= b_mag;
        acc_hi <= '0;
        cnt    <= '0;
        neg    <= is_signed & (a[N-1] ^ b[N-1]);
      end else if (iterate) begin
        acc_hi <= {lo_cout, lo_sum[N-1:1]};
        mplier <= {lo_sum[0], mplier[N-1:1]};
        cnt    <= cnt + CW'(1);
      end
      if (state != DONE && next_state == DONE) begin
        product <= final_result;
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_16b.sv
// Directed self-checking bench for mult_seq_16b: reset, unsigned/signed products,
// corner operands, start handshake and reset abort.

module tb_mult_seq_16b;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int tests_run;
  int tests_failed;

  mult_seq_16b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operands are scrambled after the start edge to show they are not re-sampled.
  task automatic start_op(input logic [15:0] op_a, input logic [15:0] op_b, input logic sgn);
    a         = op_a;
    b         = op_b;
    is_signed = sgn;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    a         = ~op_a;
    b         = ~op_b;
    is_signed = ~sgn;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) break;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    start     = 1'b1;
    is_signed = 1'b0;
    a         = 16'h0003;
    b         = 16'h0004;
    @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    tests_run++;
    if (product !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_product: got %h expected 00000000", product); end
    rst_n = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_start_ignored: busy got %b expected 0", busy); end
  endtask

  task automatic test_unsigned();
    int e;
    start_op(16'hFFFF, 16'hFFFF, 1'b0);
    wait_done(e);
    tests_run++;
    if (e !== 17) begin tests_failed++; $display("[TB] FAIL unsigned_latency: got %0d expected 17", e); end
    tests_run++;
    if (product !== 32'hFFFE0001) begin tests_failed++; $display("[TB] FAIL unsigned_product: got %h expected fffe0001", product); end
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL unsigned_busy_at_done: got %b expected 1", busy); end
    idle_cycle();
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL done_one_cycle: got %b expected 0", done); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL busy_after_done: got %b expected 0", busy); end
    tests_run++;
    if (product !== 32'hFFFE0001) begin tests_failed++; $display("[TB] FAIL product_hold: got %h expected fffe0001", product); end
  endtask

  task automatic test_signed();
    int e;
    start_op(16'hFFFD, 16'h0005, 1'b1);
    wait_done(e);
    tests_run++;
    if (e !== 18) begin tests_failed++; $display("[TB] FAIL signed_latency: got %0d expected 18", e); end
    tests_run++;
    if (product !== 32'hFFFFFFF1) begin tests_failed++; $display("[TB] FAIL signed_product: got %h expected fffffff1", product); end
    idle_cycle();
  endtask

  task automatic test_corner();
    int e;
    start_op(16'h8000, 16'h8000, 1'b1);
    wait_done(e);
    tests_run++;
    if (e !== 17) begin tests_failed++; $display("[TB] FAIL min_min_latency: got %0d expected 17", e); end
    tests_run++;
    if (product !== 32'h40000000) begin tests_failed++; $display("[TB] FAIL min_min_product: got %h expected 40000000", product); end
    idle_cycle();
    start_op(16'h8000, 16'h0001, 1'b1);
    wait_done(e);
    tests_run++;
    if (e !== 18) begin tests_failed++; $display("[TB] FAIL min_one_latency: got %0d expected 18", e); end
    tests_run++;
    if (product !== 32'hFFFF8000) begin tests_failed++; $display("[TB] FAIL min_one_product: got %h expected ffff8000", product); end
    idle_cycle();
    start_op(16'h8000, 16'h0002, 1'b0);
    wait_done(e);
    tests_run++;
    if (e !== 17) begin tests_failed++; $display("[TB] FAIL unsigned_zext_latency: got %0d expected 17", e); end
    tests_run++;
    if (product !== 32'h00010000) begin tests_failed++; $display("[TB] FAIL unsigned_zext_product: got %h expected 00010000", product); end
    idle_cycle();
    start_op(16'h0000, 16'h1234, 1'b0);
    wait_done(e);
    tests_run++;
    if (e !== 17) begin tests_failed++; $display("[TB] FAIL zero_latency: got %0d expected 17", e); end
    tests_run++;
    if (product !== 32'h0) begin tests_failed++; $display("[TB] FAIL zero_product: got %h expected 00000000", product); end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    int e;
    start_op(16'h1234, 16'h0010, 1'b0);
    e = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      e++;
      if (e == 5) begin
        start     = 1'b1;
        a         = 16'hFFFF;
        b         = 16'hFFFF;
        is_signed = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) break;
    end
    start = 1'b0;
    tests_run++;
    if (e !== 17) begin tests_failed++; $display("[TB] FAIL midcalc_latency: got %0d expected 17", e); end
    tests_run++;
    if (product !== 32'h00012340) begin tests_failed++; $display("[TB] FAIL midcalc_start_ignored: got %h expected 00012340", product); end
    idle_cycle();
    start_op(16'hFFF9, 16'hFFF7, 1'b1);
    tests_run++;
    if (product !== 32'h00012340) begin tests_failed++; $display("[TB] FAIL product_hold_busy: got %h expected 00012340", product); end
    wait_done(e);
    tests_run++;
    if (e !== 17) begin tests_failed++; $display("[TB] FAIL b2b_latency: got %0d expected 17", e); end
    tests_run++;
    if (product !== 32'h0000003F) begin tests_failed++; $display("[TB] FAIL b2b_product: got %h expected 0000003f", product); end
    idle_cycle();
  endtask

  task automatic test_abort();
    int e;
    start_op(16'h00FF, 16'h0101, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_done: got %b expected 0", done); end
    tests_run++;
    if (product !== 32'h0) begin tests_failed++; $display("[TB] FAIL abort_product: got %h expected 00000000", product); end
    start_op(16'h0003, 16'h0004, 1'b0);
    wait_done(e);
    tests_run++;
    if (e !== 17) begin tests_failed++; $display("[TB] FAIL after_abort_latency: got %0d expected 17", e); end
    tests_run++;
    if (product !== 32'h0000000C) begin tests_failed++; $display("[TB] FAIL after_abort_product: got %h expected 0000000c", product); end
    idle_cycle();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    start        = 1'b0;
    is_signed    = 1'b0;
    a            = '0;
    b            = '0;
    #1;
    test_reset();
    test_unsigned();
    test_signed();
    test_corner();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
